// File: rtl/zx8x_tape_player.sv
// Real-time ZX80/ZX81 cassette pulse generator playing a .o/.p image from the tape buffer RAM.
// Build macro ZX8X_TAPE_NAME_EN inserts a synthetic 0xA6 name byte between leader and image.
module zx8x_tape_player #(
    parameter int PULSE_HI = 7800,
    parameter int PULSE_LO = 7800,
    parameter int BIT_GAP  = 67600,
    parameter int LEAD_LEN = 26000000,
    parameter int CNT_W    = 25
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [14:0] tape_len,
    output logic [13:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEAD,
`ifdef ZX8X_TAPE_NAME_EN
        ST_NAME,
`endif
        ST_FETCH,
        ST_LOAD,
        ST_HI,
        ST_LO,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] HI_LAST   = CNT_W'(PULSE_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST   = CNT_W'(PULSE_LO - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BIT_GAP - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_LEN - 1);
    localparam logic [3:0]       PULSES_1  = 4'd9;
    localparam logic [3:0]       PULSES_0  = 4'd4;
    localparam logic [14:0]      LEN_MAX   = 15'd16384;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [7:0]         shreg_reg, shreg_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [3:0]         pulse_reg, pulse_next;
    logic [13:0]        rd_addr_reg, rd_addr_next;
    logic [13:0]        last_reg, last_next;
    logic               empty_reg, empty_next;
`ifdef ZX8X_TAPE_NAME_EN
    localparam logic [7:0] NAME_BYTE = 8'hA6;
    logic               name_phase_reg, name_phase_next;
`endif

    logic [14:0]        len_clamped;
    logic [13:0]        len_last;

    // Oversized lengths play the whole 16K buffer; the last index is kept
    // instead of the length so the end test is a 14-bit compare.
    assign len_clamped = (tape_len > LEN_MAX) ? LEN_MAX : tape_len;
    assign len_last    = 14'(len_clamped - 15'd1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            shreg_reg      <= '0;
            bit_idx_reg    <= '0;
            pulse_reg      <= '0;
            rd_addr_reg    <= '0;
            last_reg       <= '0;
            empty_reg      <= 1'b0;
`ifdef ZX8X_TAPE_NAME_EN
            name_phase_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shreg_reg      <= shreg_next;
            bit_idx_reg    <= bit_idx_next;
            pulse_reg      <= pulse_next;
            rd_addr_reg    <= rd_addr_next;
            last_reg       <= last_next;
            empty_reg      <= empty_next;
`ifdef ZX8X_TAPE_NAME_EN
            name_phase_reg <= name_phase_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = '0;
        shreg_next      = shreg_reg;
        bit_idx_next    = bit_idx_reg;
        pulse_next      = pulse_reg;
        rd_addr_next    = rd_addr_reg;
        last_next       = last_reg;
        empty_next      = empty_reg;
`ifdef ZX8X_TAPE_NAME_EN
        name_phase_next = name_phase_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_LEAD;
                    rd_addr_next = '0;
                    last_next    = len_last;
                    empty_next   = (len_clamped == 15'd0);
                end
            end

            ST_LEAD: begin
                if (cnt_reg == LEAD_LAST) begin
                    if (empty_reg) begin
                        state_next = ST_DONE;
                    end else begin
`ifdef ZX8X_TAPE_NAME_EN
                        state_next      = ST_NAME;
                        name_phase_next = 1'b1;
`else
                        state_next = ST_FETCH;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

`ifdef ZX8X_TAPE_NAME_EN
            ST_NAME: begin
                shreg_next   = NAME_BYTE;
                bit_idx_next = 3'd7;
                pulse_next   = NAME_BYTE[7] ? PULSES_1 : PULSES_0;
                state_next   = ST_HI;
            end
`endif

            // Address settles in FETCH; the RAM output is valid in LOAD.
            ST_FETCH: begin
                state_next = ST_LOAD;
            end

            ST_LOAD: begin
                shreg_next   = rd_data;
                bit_idx_next = 3'd7;
                pulse_next   = rd_data[7] ? PULSES_1 : PULSES_0;
                state_next   = ST_HI;
            end

            ST_HI: begin
                if (cnt_reg == HI_LAST) begin
                    state_next = ST_LO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_LO: begin
                if (cnt_reg == LO_LAST) begin
                    if (pulse_reg == 4'd1) begin
                        state_next = ST_GAP;
                    end else begin
                        pulse_next = pulse_reg - 1'b1;
                        state_next = ST_HI;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_reg != GAP_LAST) begin
                    cnt_next = cnt_reg + 1'b1;
                end else if (bit_idx_reg != 3'd0) begin
                    // Rotate instead of shift: the wrapped bit is never played.
                    shreg_next   = {shreg_reg[6:0], shreg_reg[7]};
                    bit_idx_next = bit_idx_reg - 1'b1;
                    pulse_next   = shreg_reg[6] ? PULSES_1 : PULSES_0;
                    state_next   = ST_HI;
`ifdef ZX8X_TAPE_NAME_EN
                end else if (name_phase_reg) begin
                    name_phase_next = 1'b0;
                    state_next      = ST_FETCH;
`endif
                end else if (rd_addr_reg != last_reg) begin
                    rd_addr_next = rd_addr_reg + 1'b1;
                    state_next   = ST_FETCH;
                end else begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort beats everything, including a start in the same cycle.
        if (stop) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
`ifdef ZX8X_TAPE_NAME_EN
            name_phase_next = 1'b0;
`endif
        end
    end

    assign rd_addr  = rd_addr_reg;
    assign tape_out = (state_reg == ST_HI);
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_zx8x_tape_player.sv
// Scoreboard bench for zx8x_tape_player with short timing parameters.
// Honours ZX8X_TAPE_NAME_EN the same way as the design.
module tb_zx8x_tape_player;

    localparam int PULSE_HI = 4;
    localparam int PULSE_LO = 4;
    localparam int BIT_GAP  = 20;
    localparam int LEAD_LEN = 10;

    localparam int K_BIT  = 0;
    localparam int K_ADDR = 1;
    localparam int K_DONE = 2;

`ifdef ZX8X_TAPE_NAME_EN
    localparam int NAME_BITS  = 8;
    localparam int LEAD_TO_HI = 11;
    localparam int T2_DONE    = 1034;
`else
    localparam int NAME_BITS  = 0;
    localparam int LEAD_TO_HI = 12;
    localparam int T2_DONE    = 456;
`endif

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic        clk_sys;
    logic        reset;
    logic        start;
    logic        stop;
    logic [14:0] tape_len;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        tape_out;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:16383];

    ev_t         exp_q[$];
    int          tests_run = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          mon_en = 0;

    int          hi_run = 0, lo_run = 0, pulse_cnt = 0, bits_seen = 0, done_cnt = 0;
    int          first_hi_cyc = -1, done_cyc = -1, busy_rise_cyc = -1;
    logic        prev_tape = 0, prev_busy = 0;
    logic [13:0] prev_addr = '0;

    zx8x_tape_player #(
        .PULSE_HI (PULSE_HI),
        .PULSE_LO (PULSE_LO),
        .BIT_GAP  (BIT_GAP),
        .LEAD_LEN (LEAD_LEN),
        .CNT_W    (8)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .tape_len (tape_len),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tape_out (tape_out),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk_sys = 0;
        forever #5 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) begin
        rd_data <= mem[rd_addr];
        cyc     <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push(K_BIT, b[i] ? 9 : 4);
    endtask

    task automatic push_name();
`ifdef ZX8X_TAPE_NAME_EN
        push_byte(8'hA6);
`endif
    endtask

    task automatic mon_pop(input int kind, input int val);
        ev_t e;
        $display("[MON] cyc=%0d kind=%0d val=%0d", cyc, kind, val);
        if (!mon_en) return;
        if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d, expected nothing", kind, val);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_val", val, e.val);
        end
    endtask

    // Monitor: turns the tape waveform into bit/address/done events.
    always @(negedge clk_sys) begin
        if (reset) begin
            hi_run = 0; lo_run = 0; pulse_cnt = 0;
            prev_tape = 0; prev_busy = 0; prev_addr = rd_addr;
        end else begin
            if (tape_out) begin
                if (!prev_tape) begin
                    if (pulse_cnt > 0 && mon_en) check("lo_width", lo_run, PULSE_LO);
                    if (first_hi_cyc < 0) first_hi_cyc = cyc;
                    pulse_cnt++;
                    hi_run = 0;
                end
                hi_run++;
                lo_run = 0;
            end else begin
                if (prev_tape && mon_en) check("hi_width", hi_run, PULSE_HI);
                lo_run++;
                if (pulse_cnt > 0 && lo_run == PULSE_LO + 1) begin
                    bits_seen++;
                    mon_pop(K_BIT, pulse_cnt);
                    pulse_cnt = 0;
                end
            end
            if (rd_addr != prev_addr) mon_pop(K_ADDR, int'(rd_addr));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                mon_pop(K_DONE, 0);
            end
            if (busy && !prev_busy) busy_rise_cyc = cyc;
            prev_tape = tape_out;
            prev_busy = busy;
            prev_addr = rd_addr;
        end
    end

    task automatic do_start(input logic [14:0] len);
        @(negedge clk_sys);
        tape_len = len;
        start    = 1;
        @(negedge clk_sys);
        start    = 0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(busy !== 1'b0), 0);
    endtask

    initial begin
        int done_base;
        int target;
        int n;
        reset = 1; start = 0; stop = 0; tape_len = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk_sys);
        check("rst_tape_out", tape_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", rd_addr, 0);
        reset = 0;
        mon_en = 1;
        repeat (2) @(negedge clk_sys);

        // One byte 0x80: one long bit, seven short bits.
        mem[0] = 8'h80;
        first_hi_cyc = -1;
        push_name(); push_byte(8'h80); push(K_DONE, 0);
        do_start(15'd1);
        check("t2_busy", busy, 1);
        wait_idle(3000, "t2");
        check("t2_lead", first_hi_cyc - busy_rise_cyc, LEAD_TO_HI);
        check("t2_done_time", done_cyc - first_hi_cyc, T2_DONE);
        check("t2_drain", exp_q.size(), 0);

        // Three bytes with address stepping.
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55;
        done_base = done_cnt;
        push_name(); push_byte(8'h00); push(K_ADDR, 1);
        push_byte(8'hFF); push(K_ADDR, 2); push_byte(8'h55); push(K_DONE, 0);
        do_start(15'd3);
        wait_idle(6000, "t3");
        check("t3_done_count", done_cnt - done_base, 1);
        check("t3_rd_addr", rd_addr, 2);
        check("t3_drain", exp_q.size(), 0);

        // Stop in the gap of byte 1's third bit, then replay from address 0.
        done_base = done_cnt;
        target = bits_seen + NAME_BITS + 11;
        push(K_ADDR, 0); push_name(); push_byte(8'h00); push(K_ADDR, 1);
        push(K_BIT, 9); push(K_BIT, 9); push(K_BIT, 9);
        do_start(15'd3);
        n = 0;
        while (bits_seen < target && n < 6000) begin
            @(negedge clk_sys);
            n++;
        end
        check("t4_reach_gap", 32'(bits_seen >= target), 1);
        stop = 1;
        @(negedge clk_sys);
        stop = 0;
        check("t4_stop_busy", busy, 0);
        check("t4_stop_tape", tape_out, 0);
        repeat (60) @(negedge clk_sys);
        check("t4_no_done", done_cnt - done_base, 0);
        check("t4_drain", exp_q.size(), 0);
        push(K_ADDR, 0); push_name(); push_byte(8'h00); push(K_ADDR, 1);
        push_byte(8'hFF); push(K_DONE, 0);
        do_start(15'd2);
        wait_idle(5000, "t4r");
        check("t4r_drain", exp_q.size(), 0);

        // Empty image, with an ignored start while busy.
        done_base = done_cnt;
        push(K_ADDR, 0); push(K_DONE, 0);
        do_start(15'd0);
        repeat (3) @(negedge clk_sys);
        tape_len = 15'd2;
        start = 1;
        @(negedge clk_sys);
        start = 0;
        wait_idle(200, "t5");
        repeat (30) @(negedge clk_sys);
        check("t5_done_time", done_cyc - busy_rise_cyc, 10);
        check("t5_done_count", done_cnt - done_base, 1);
        check("t5_drain", exp_q.size(), 0);

`ifdef ZX8X_TAPE_NAME_EN
        // Name byte ahead of a single zero byte; address never moves.
        mem[0] = 8'h00;
        push_name(); push_byte(8'h00); push(K_DONE, 0);
        do_start(15'd1);
        wait_idle(3000, "t6");
        check("t6_rd_addr", rd_addr, 0);
        check("t6_drain", exp_q.size(), 0);
`endif

        // Asynchronous reset while a pulse is high on byte 1.
        mon_en = 0;
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55;
        do_start(15'd3);
        n = 0;
        while (!(rd_addr == 14'd1 && tape_out === 1'b1) && n < 6000) begin
            @(negedge clk_sys);
            n++;
        end
        check("t1_pre_hi", tape_out, 1);
        #2 reset = 1;
        #1;
        check("t1_tape_out", tape_out, 0);
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        check("t1_rd_addr", rd_addr, 0);
        @(negedge clk_sys);
        reset = 0;
        repeat (2) @(negedge clk_sys);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
